// File: rtl/acc_pkg.sv
// ============================================================================
//  Module      : acc_pkg
//  Description : Shared mode encoding and nibble width for the accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package acc_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } shift_mode_t;

endpackage : acc_pkg

`default_nettype wire

// File: rtl/acc_shift4.sv
// ============================================================================
//  Module      : shift4
//  Description : 4-bit universal shift register (hold / shift right /
//                shift left / parallel load) with async and sync clear.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift4
    import acc_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              sclr,
    input  shift_mode_t       mode,
    input  logic              sr_in,
    input  logic              sl_in,
    input  logic [NIB_W-1:0]  d,
    output logic [NIB_W-1:0]  q
);

    logic [NIB_W-1:0] w_next;

    always_comb begin
        w_next = q;
        case (mode)
            HOLD:    w_next = q;
            SHR:     w_next = {sr_in, q[NIB_W-1:1]};
            SHL:     w_next = {q[NIB_W-2:0], sl_in};
            LOAD:    w_next = d;
            default: w_next = q;
        endcase
    end

    // Synchronous clear outranks every mode.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= '0;
        end else if (sclr) begin
            q <= '0;
        end else begin
            q <= w_next;
        end
    end

endmodule : shift4

`default_nettype wire

// File: rtl/acc.sv
// ============================================================================
//  Module      : acc
//  Description : 8-bit accumulator built from two cascaded 4-bit universal
//                shift registers (AH high, AL low). Define ACC_ROTATE_EN to
//                make the 8-bit register rotate instead of shift.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module acc
    import acc_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              ah_reset,
    input  logic [1:0]        hs,
    input  logic [1:0]        ls,
    input  logic              ah_inen,
    input  logic [NIB_W-1:0]  ah_in,
    input  logic [NIB_W-1:0]  aludata,
    input  logic              carry_out,
    output logic [NIB_W-1:0]  ah_out,
    output logic [NIB_W-1:0]  al_out
);

    logic              r_run;
    shift_mode_t       w_hs_mode;
    shift_mode_t       w_ls_mode;
    logic              w_ah_sclr;
    logic [NIB_W-1:0]  w_ah_d;
    logic              w_ah_sr_in;
    logic              w_al_sl_in;

    // Clear release is registered once, so the first real update lands on
    // the second rising edge after clr_n deasserts.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_hs_mode = r_run ? shift_mode_t'(hs) : HOLD;
    assign w_ls_mode = r_run ? shift_mode_t'(ls) : HOLD;
    assign w_ah_sclr = r_run & ah_reset;
    assign w_ah_d    = ah_inen ? ah_in : aludata;

`ifdef ACC_ROTATE_EN
    logic w_unused_carry;
    assign w_unused_carry = carry_out;
    assign w_ah_sr_in     = al_out[0];
    assign w_al_sl_in     = ah_out[NIB_W-1];
`else
    assign w_ah_sr_in     = carry_out;
    assign w_al_sl_in     = 1'b0;
`endif

    shift4 u_ah (
        .clk   (clk),
        .clr_n (clr_n),
        .sclr  (w_ah_sclr),
        .mode  (w_hs_mode),
        .sr_in (w_ah_sr_in),
        .sl_in (al_out[NIB_W-1]),
        .d     (w_ah_d),
        .q     (ah_out)
    );

    shift4 u_al (
        .clk   (clk),
        .clr_n (clr_n),
        .sclr  (1'b0),
        .mode  (w_ls_mode),
        .sr_in (ah_out[0]),
        .sl_in (w_al_sl_in),
        .d     (aludata),
        .q     (al_out)
    );

endmodule : acc

`default_nettype wire

// File: tb/tb_acc.sv
// ============================================================================
//  Module      : tb_acc
//  Description : Directed, table-driven self-checking bench for acc.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_acc;

    logic       clk;
    logic       clr_n;
    logic       ah_reset;
    logic [1:0] hs;
    logic [1:0] ls;
    logic       ah_inen;
    logic [3:0] ah_in;
    logic [3:0] aludata;
    logic       carry_out;
    logic [3:0] ah_out;
    logic [3:0] al_out;

    int n_total;
    int n_pass;

    acc dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .ah_reset  (ah_reset),
        .hs        (hs),
        .ls        (ls),
        .ah_inen   (ah_inen),
        .ah_in     (ah_in),
        .aludata   (aludata),
        .carry_out (carry_out),
        .ah_out    (ah_out),
        .al_out    (al_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       ah_reset;
        logic [1:0] hs;
        logic [1:0] ls;
        logic       ah_inen;
        logic [3:0] ah_in;
        logic [3:0] aludata;
        logic       carry_out;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] h, input logic [1:0] l,
                         input logic en, input logic [3:0] ai, input logic [3:0] ad,
                         input logic co);
        ah_reset  = r;
        hs        = h;
        ls        = l;
        ah_inen   = en;
        ah_in     = ai;
        aludata   = ad;
        carry_out = co;
    endtask

    function automatic vec_t mk(input string n, input logic r, input logic [1:0] h,
                                input logic [1:0] l, input logic en, input logic [3:0] ai,
                                input logic [3:0] ad, input logic co, input logic [7:0] e);
        vec_t v;
        v.name = n; v.ah_reset = r; v.hs = h; v.ls = l; v.ah_inen = en;
        v.ah_in = ai; v.aludata = ad; v.carry_out = co; v.exp = e;
        return v;
    endfunction

    initial begin
        n_total = 0;
        n_pass  = 0;

        vecs.push_back(mk("load_alu",      0, 2'b11, 2'b00, 0, 4'h5, 4'h2, 0, 8'h20));
        vecs.push_back(mk("load_ah_in",    0, 2'b11, 2'b00, 1, 4'h5, 4'h2, 0, 8'h50));
        vecs.push_back(mk("load_al",       0, 2'b00, 2'b11, 0, 4'h5, 4'h2, 0, 8'h52));
        vecs.push_back(mk("shr_c0",        0, 2'b01, 2'b01, 0, 4'h5, 4'h2, 0, 8'h29));
        vecs.push_back(mk("reload_52",     0, 2'b11, 2'b11, 1, 4'h5, 4'h2, 0, 8'h52));
        vecs.push_back(mk("shr_c1",        0, 2'b01, 2'b01, 0, 4'h5, 4'h2, 1, 8'hA9));
        vecs.push_back(mk("reload_29",     0, 2'b11, 2'b11, 1, 4'h2, 4'h9, 0, 8'h29));
        vecs.push_back(mk("mixed_shl_shr", 0, 2'b10, 2'b01, 0, 4'h5, 4'h2, 0, 8'h54));
        vecs.push_back(mk("shl_both",      0, 2'b10, 2'b10, 0, 4'h5, 4'h2, 0, 8'hA8));
        vecs.push_back(mk("ah_reset_hold", 1, 2'b00, 2'b00, 0, 4'h5, 4'h2, 0, 8'h08));
        vecs.push_back(mk("ah_reset_load", 1, 2'b11, 2'b00, 0, 4'h5, 4'h2, 0, 8'h08));
        vecs.push_back(mk("hold",          0, 2'b00, 2'b00, 0, 4'h5, 4'h2, 1, 8'h08));
        vecs.push_back(mk("ah_reset_al_sh",1, 2'b11, 2'b01, 0, 4'h5, 4'h2, 0, 8'h04));
        vecs.push_back(mk("load_81",       0, 2'b11, 2'b11, 1, 4'h8, 4'h1, 0, 8'h81));
`ifdef ACC_ROTATE_EN
        vecs.push_back(mk("rot_left",      0, 2'b10, 2'b10, 0, 4'h5, 4'h2, 0, 8'h03));
`else
        vecs.push_back(mk("shl_fill0",     0, 2'b10, 2'b10, 0, 4'h5, 4'h2, 0, 8'h02));
`endif
        vecs.push_back(mk("load_01",       0, 2'b11, 2'b11, 1, 4'h0, 4'h1, 0, 8'h01));
`ifdef ACC_ROTATE_EN
        vecs.push_back(mk("rot_right",     0, 2'b01, 2'b01, 0, 4'h5, 4'h2, 0, 8'h80));
`else
        vecs.push_back(mk("shr_fill_c0",   0, 2'b01, 2'b01, 0, 4'h5, 4'h2, 0, 8'h00));
`endif

        // Asynchronous clear mid-cycle, no clock edge needed.
        clr_n = 1'b1;
        drive(0, 2'b00, 2'b00, 0, 4'h5, 4'h2, 0);
        #2 clr_n = 1'b0;
        #1;
        check("reset_ah", {4'h0, ah_out}, 8'h00);
        check("reset_al", {4'h0, al_out}, 8'h00);

        // Release: the first edge must not update, the second one must.
        @(negedge clk);
        clr_n = 1'b1;
        drive(0, 2'b11, 2'b00, 1, 4'h5, 4'h2, 0);
        @(posedge clk); #1;
        check("sync_edge1", {ah_out, al_out}, 8'h00);
        @(posedge clk); #1;
        check("sync_edge2", {ah_out, al_out}, 8'h50);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ah_reset, vecs[i].hs, vecs[i].ls, vecs[i].ah_inen,
                  vecs[i].ah_in, vecs[i].aludata, vecs[i].carry_out);
            @(posedge clk); #1;
            check(vecs[i].name, {ah_out, al_out}, vecs[i].exp);
        end

        // Clear asserted in the middle of a shift aborts it.
        @(negedge clk);
        drive(0, 2'b11, 2'b11, 1, 4'hA, 4'h5, 0);
        @(posedge clk); #1;
        check("load_A5", {ah_out, al_out}, 8'hA5);
        @(negedge clk);
        drive(0, 2'b01, 2'b01, 0, 4'h5, 4'h2, 1);
        #2 clr_n = 1'b0;
        #1;
        check("abort_now", {ah_out, al_out}, 8'h00);
        @(posedge clk); #1;
        check("abort_held", {ah_out, al_out}, 8'h00);

        // Second release with a load pending: still two edges to first update.
        @(negedge clk);
        clr_n = 1'b1;
        drive(0, 2'b11, 2'b11, 0, 4'h5, 4'h2, 0);
        @(posedge clk); #1;
        check("resync_edge1", {ah_out, al_out}, 8'h00);
        @(posedge clk); #1;
        check("resync_edge2", {ah_out, al_out}, 8'h22);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_acc

`default_nettype wire
